// File: rtl/drv_irq_pkg.sv
// Shared constants for the driver-monitor interrupt controller.
package drv_irq_pkg;

    localparam logic MODE_LEVEL      = 1'b0;
    localparam logic MODE_EDGE       = 1'b1;
    localparam int   DEFAULT_NUM_SRC = 4;
    localparam int   MAX_NUM_SRC     = 32;

endpackage

// File: rtl/drv_irq_prio_enc.sv
// Combinational priority encoder: the highest set index wins.
module drv_irq_prio_enc #(
    parameter  int NUM_SRC = 4,
    localparam int ID_W    = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] vector,
    output logic               any,
    output logic [ID_W-1:0]    idx
);

    // Ascending scan so the last (highest) set bit overrides lower ones.
    always_comb begin
        idx = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (vector[i]) begin
                idx = ID_W'(i);
            end
        end
    end

    assign any = |vector;

endmodule

// File: rtl/drv_irq_ctrl.sv
// NUM_SRC-source interrupt controller with edge/level capture, masking and ack handshake.
// Optional preemption of a presented interrupt is enabled by defining DRV_IRQ_PREEMPT_EN.
module drv_irq_ctrl
    import drv_irq_pkg::*;
#(
    parameter  int NUM_SRC = DEFAULT_NUM_SRC,
    localparam int ID_W    = $clog2(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_in,
    input  logic [NUM_SRC-1:0] src_edge,
    input  logic [NUM_SRC-1:0] irq_mask,
    input  logic               irq_ack,
    output logic               irq_valid,
    output logic [ID_W-1:0]    irq_id,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] overrun
);

    logic [NUM_SRC-1:0] src_q_reg;
    logic [NUM_SRC-1:0] pending_reg, pending_next;
    logic [NUM_SRC-1:0] overrun_reg, overrun_next;
    logic               valid_reg, valid_next;
    logic [ID_W-1:0]    id_reg, id_next;

    logic [NUM_SRC-1:0] evt;
    logic [NUM_SRC-1:0] clr;
    logic [NUM_SRC-1:0] cand;
    logic               cand_any;
    logic [ID_W-1:0]    win_idx;
    logic               ack_ok;

    assign ack_ok = irq_ack && valid_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign evt[gi] = (src_edge[gi] == MODE_EDGE) ? (src_in[gi] && !src_q_reg[gi])
                                                         : src_in[gi];
            assign clr[gi] = ack_ok && (id_reg == ID_W'(gi));
        end
    endgenerate

    // New events are OR-ed in after the clear so a same-cycle set is never lost.
    assign pending_next = (pending_reg & ~clr) | evt;
    assign overrun_next = (overrun_reg & ~clr) | (evt & src_edge & pending_reg);
    assign cand         = pending_reg & ~irq_mask;

    drv_irq_prio_enc #(
        .NUM_SRC (NUM_SRC)
    ) u_prio_enc (
        .vector (cand),
        .any    (cand_any),
        .idx    (win_idx)
    );

    // Presentation only starts from an idle cycle, which forces a gap after every ack.
    always_comb begin
        valid_next = valid_reg;
        id_next    = id_reg;
        if (ack_ok) begin
            valid_next = 1'b0;
        end else if (!valid_reg) begin
            if (cand_any) begin
                valid_next = 1'b1;
                id_next    = win_idx;
            end
        end
`ifdef DRV_IRQ_PREEMPT_EN
        else if (cand_any && (win_idx > id_reg)) begin
            id_next = win_idx;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_q_reg   <= '0;
            pending_reg <= '0;
            overrun_reg <= '0;
            valid_reg   <= 1'b0;
            id_reg      <= '0;
        end else begin
            src_q_reg   <= src_in;
            pending_reg <= pending_next;
            overrun_reg <= overrun_next;
            valid_reg   <= valid_next;
            id_reg      <= id_next;
        end
    end

    assign irq_valid = valid_reg;
    assign irq_id    = id_reg;
    assign pending   = pending_reg;
    assign overrun   = overrun_reg;

endmodule

// File: doc/drv_irq_ctrl.md
Name: drv_irq_ctrl

Overview:
Parametrised interrupt controller for the driver-monitor subsystem. It generalises the fixed two-source emergency/warn scheme to NUM_SRC sources with per-source edge or level mode, masking, sticky pending bits, overrun flags and a registered ack handshake. It sits between the monitor detectors (fatigue, distraction, emergency, warn, …) and the host/CPU interrupt line.

Parameters:
NUM_SRC, 4, number of interrupt sources; index NUM_SRC-1 is highest priority; legal range 2..32
ID_W, $clog2(NUM_SRC), width of irq_id; derived, not overridden

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
src_in  input  NUM_SRC  source request lines, synchronous to clk (synchronised upstream)
src_edge  input  NUM_SRC  per-source mode; 1 = rising edge, 0 = level-high
irq_mask  input  NUM_SRC  per-source mask; 1 = blocked from presentation, still captured
irq_ack  input  1  host acknowledge of the presented interrupt
irq_valid  output  1  an interrupt is being presented
irq_id  output  ID_W  index of the presented source; meaningful only while irq_valid = 1
pending  output  NUM_SRC  sticky pending bits, registered
overrun  output  NUM_SRC  sticky flag: a new edge arrived while that source was already pending

Behaviour:
- Reset (rst = 0, async): src_q, pending, overrun and irq_valid all 0; irq_id = 0.
- Event detect: in edge mode, evt[i] = src_in[i] & ~src_q[i], where src_q is the previous-cycle sample. In level mode, evt[i] = src_in[i].
- Pending: pending[i] is set on evt[i] whether or not the source is masked. It is cleared only by an accepted ack of that source.
- Overrun: overrun[i] is set when evt[i] fires in edge mode while pending[i] = 1. It is cleared on an accepted ack of source i. Level-mode sources never set overrun.
- Candidate: cand = pending & ~irq_mask. The winner is the highest set index.
- Presentation, idle: when irq_valid = 0 and cand != 0, irq_valid is set to 1 and irq_id is set to the winner on the next clock edge.
- Latency: a src_in edge sampled at edge n gives pending at n+1 and irq_valid at n+2.
- Presentation, held: while irq_valid = 1, irq_id is stable until ack. A later mask change does not withdraw the presented interrupt.
- Ack accepted (irq_ack = 1 and irq_valid = 1):
  - clear pending[irq_id] and overrun[irq_id];
  - irq_valid goes to 0 on the next edge;
  - the next winner is presented no earlier than the following edge, so there is always at least one idle cycle between interrupts.
- Ack with irq_valid = 0: ignored, no state change.
- Set and clear in the same cycle on the same source: the set wins. An edge arriving in the ack cycle is not lost. A level source that is still high re-pends immediately.
- All sources masked: pending still accumulates and irq_valid stays 0. Unmasking presents the pending source on the next edge.
- Mode change while pending: the existing pending bit is kept; the new mode applies to subsequent events only.
- Reset mid-handshake: all state is cleared, and an ack arriving after reset is ignored.

Optional Feature:
Macro: DRV_IRQ_PREEMPT_EN.
- Defined: while irq_valid = 1 and not acked, if the candidate set contains an index higher than irq_id, irq_id updates to that index on the next edge and irq_valid stays 1. An ack always applies to the irq_id registered in the ack cycle.
- Undefined: irq_id is held until ack, exactly as described under Behaviour.

Decomposition:
- Package drv_irq_pkg: constants MODE_LEVEL = 1'b0 and MODE_EDGE = 1'b1; default NUM_SRC; max-source limit 32.
- Sub-module drv_irq_prio_enc: purely combinational highest-index-wins priority encoder. Parameter NUM_SRC; inputs vector; outputs any and idx. It is instantiated once and is unit-testable on its own.

Test Plan:
1. NUM_SRC=4, all edge mode, mask=0. Pulse src_in[1] at cycle 10 -> pending=0010 at 11, irq_valid=1 and irq_id=1 at 12. Ack at 14 -> irq_valid=0 and pending=0000 at 15.
2. Raise src_in[0] and src_in[3] in the same cycle -> irq_id=3 presented first. Ack -> one idle cycle, then irq_id=0.
3. mask=1000 and pulse src_in[3] -> pending[3]=1 with irq_valid held at 0. Clear the mask -> irq_id=3 presented next cycle.
4. Edge source 2 pulses twice before ack -> overrun[2]=1. Ack -> pending[2]=0 and overrun[2]=0. Then make source 2 level mode and hold it high -> re-presents irq_id=2 after the idle cycle.
5. Present irq_id=1, then pulse src_in[3] before ack -> with DRV_IRQ_PREEMPT_EN, irq_id becomes 3 next edge; without it, irq_id stays 1 until ack.
6. Assert rst=0 mid-presentation (irq_valid=1, pending=0110) -> all outputs 0 immediately. An ack after release is ignored.
